// File: rtl/sb_trig_scaler.sv
// Trigger rate scaler with programmable holdoff (dead time).
// Accepted triggers are forwarded as TRIG_OUT. Accepted and holdoff-suppressed
// triggers are counted per GPS 1PPS interval and latched for software, with a
// VALID/ACK handshake and a sticky OVERRUN flag.
module sb_trig_scaler #(
  parameter int CNT_WIDTH     = 24,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     CLK120,
  input  logic                     RESET,
  input  logic                     TRIG,
  input  logic                     PPS,
  input  logic                     ENABLE,
  input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF,
  input  logic                     ACK,
  output logic                     TRIG_OUT,
  output logic [CNT_WIDTH-1:0]     COUNT,
  output logic [CNT_WIDTH-1:0]     SUPPRESSED,
  output logic                     VALID,
  output logic                     OVERRUN
);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE = CNT_WIDTH'(1);
  localparam logic [HOLDOFF_WIDTH-1:0] HO_ONE  = HOLDOFF_WIDTH'(1);

  // PPS synchronizer and edge-detect stage
  logic pps_s1_q, pps_s2_q, pps_s3_q;
  logic pps_rise;

  // Holdoff and interval counters
  logic [HOLDOFF_WIDTH-1:0] ho_cnt_q, ho_cnt_d;
  logic [CNT_WIDTH-1:0]     acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]     rej_cnt_q, rej_cnt_d;

  // Registered outputs
  logic                 trig_out_q, trig_out_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] supp_q, supp_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic accept, reject;

  // Bring the asynchronous PPS into the CLK120 domain.
  // NOTE: PPS_S1 may go metastable; only PPS_S2/PPS_S3 are used by logic,
  // so PPS_S1 gets a full cycle to resolve before anything depends on it.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      pps_s1_q <= 1'b0;
      pps_s2_q <= 1'b0;
      pps_s3_q <= 1'b0;
    end else begin
      pps_s1_q <= PPS;
      pps_s2_q <= pps_s1_q;
      pps_s3_q <= pps_s2_q;
    end
  end

  assign pps_rise = pps_s2_q && !pps_s3_q;

  // A trigger is only judged while enabled; a running holdoff rejects it.
  assign accept = TRIG && ENABLE && (ho_cnt_q == '0);
  assign reject = TRIG && ENABLE && (ho_cnt_q != '0);

  // Next-state logic for holdoff, interval counters and the latched outputs.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    ho_cnt_d   = ho_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    trig_out_d = accept;
    count_d    = count_q;
    supp_d     = supp_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    // Holdoff: reload on accept, otherwise run down to zero. HOLDOFF is only
    // sampled at an accept, so changing it mid-holdoff has no effect.
    if (!ENABLE) begin
      ho_cnt_d = '0;
    end else if (accept) begin
      ho_cnt_d = HOLDOFF;
    end else if (ho_cnt_q != '0) begin
      ho_cnt_d = ho_cnt_q - HO_ONE;
    end

    if (pps_rise) begin
      // Close the interval. An event in this same cycle opens the next one.
      count_d   = acc_cnt_q;
      supp_d    = rej_cnt_q;
      acc_cnt_d = accept ? CNT_ONE : '0;
      rej_cnt_d = reject ? CNT_ONE : '0;
      valid_d   = 1'b1;
      if (ACK) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else begin
      // Counters saturate rather than wrap.
      if (accept && (acc_cnt_q != CNT_MAX)) begin
        acc_cnt_d = acc_cnt_q + CNT_ONE;
      end
      if (reject && (rej_cnt_q != CNT_MAX)) begin
        rej_cnt_d = rej_cnt_q + CNT_ONE;
      end
      if (ACK) begin
        valid_d   = 1'b0;
        overrun_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      ho_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      rej_cnt_q  <= '0;
      trig_out_q <= 1'b0;
      count_q    <= '0;
      supp_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      ho_cnt_q   <= ho_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
      trig_out_q <= trig_out_d;
      count_q    <= count_d;
      supp_q     <= supp_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign TRIG_OUT   = trig_out_q;
  assign COUNT      = count_q;
  assign SUPPRESSED = supp_q;
  assign VALID      = valid_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: doc/sb_trig_scaler.md
# sb_trig_scaler

Rate scaler and dead-time stage placed directly downstream of the 120 MHz single-bin trigger. It applies a programmable holdoff after each accepted trigger and forwards accepted triggers as TRIG_OUT. It counts accepted and holdoff-suppressed triggers and latches both counts into software-readable registers on every GPS 1PPS edge. A valid/acknowledge handshake and a sticky overrun flag tell software when an interval was missed.

## Interface
- CNT_WIDTH, 24, width of accepted/suppressed counters and latched outputs
- HOLDOFF_WIDTH, 16, width of holdoff setting and holdoff counter

- CLK120  in  1  120 MHz trigger clock
- RESET  in  1  reset, synchronous, active-high
- TRIG  in  1  single-cycle trigger pulse from single-bin trigger
- PPS  in  1  GPS 1PPS, asynchronous to CLK120
- ENABLE  in  1  scaler/forwarding enable, CLK120 domain
- HOLDOFF  in  HOLDOFF_WIDTH  dead time in CLK120 cycles, sampled at each accept
- ACK  in  1  software read acknowledge, single-cycle pulse
- TRIG_OUT  out  1  accepted trigger, single-cycle pulse
- COUNT  out  CNT_WIDTH  accepted triggers in last completed PPS interval
- SUPPRESSED  out  CNT_WIDTH  triggers rejected by holdoff in last completed interval
- VALID  out  1  new COUNT/SUPPRESSED available
- OVERRUN  out  1  sticky: an interval latched while VALID still set

## Operation
- PPS sync: PPS_S1 <= PPS, PPS_S2 <= PPS_S1, PPS_S3 <= PPS_S2; PPS_RISE = PPS_S2 && !PPS_S3.
- Holdoff counter HO_CNT (HOLDOFF_WIDTH bits):
  - ACCEPT = TRIG && ENABLE && (HO_CNT == 0).
  - REJECT = TRIG && ENABLE && (HO_CNT != 0).
  - ACCEPT: HO_CNT <= HOLDOFF. Else if HO_CNT != 0: HO_CNT <= HO_CNT-1.
  - ENABLE=0: HO_CNT <= 0. TRIG is neither accepted nor rejected.
- TRIG_OUT <= ACCEPT.
- ACC_CNT increments on ACCEPT. REJ_CNT increments on REJECT. Both saturate at all-ones and never wrap.
- On PPS_RISE:
  - COUNT <= ACC_CNT, SUPPRESSED <= REJ_CNT, VALID <= 1.
  - ACC_CNT and REJ_CNT restart at 0, or at 1 if an ACCEPT/REJECT occurs in the same cycle. That event belongs to the new interval.
- Handshake:
  - ACK alone: VALID <= 0, OVERRUN <= 0.
  - PPS_RISE with VALID=1 and no ACK: OVERRUN <= 1. COUNT/SUPPRESSED are overwritten with the newest data.
  - ACK and PPS_RISE in the same cycle: VALID stays 1 (new data), OVERRUN <= 0.
- HOLDOFF=0: no dead time; every enabled TRIG is accepted.
- HOLDOFF changes while HO_CNT != 0 do not affect the running holdoff.

## Timing
- Reset (synchronous): TRIG_OUT, COUNT, SUPPRESSED, VALID, OVERRUN = 0; HO_CNT, ACC_CNT, REJ_CNT, PPS_S1..S3 = 0.
- RESET during holdoff or mid-interval: all state is discarded. The first PPS_RISE after reset latches only the events counted since reset.
- TRIG -> TRIG_OUT latency: 1 cycle.
- Accept sampled at edge n:
  - TRIG at edges n+1 .. n+HOLDOFF is suppressed.
  - TRIG at edge n+HOLDOFF+1 is accepted.
- PPS -> VALID:
  - PPS sampled high first at edge k: COUNT/VALID update at edge k+2.
  - PPS held high produces one latch only; a new rising edge is required.
- A PPS pulse shorter than one CLK120 period may be missed; this is acceptable because GPS PPS width is at least 1 µs.

## Test plan
- Basic count: HOLDOFF=0, ENABLE=1, 10 TRIG pulses spaced 3 cycles, then PPS rise -> 10 TRIG_OUT pulses each 1 cycle after TRIG; at edge k+2 COUNT=10, SUPPRESSED=0, VALID=1.
- Holdoff boundary: HOLDOFF=5, TRIG at edges 0, 5, 6 -> edge 0 accepted, edge 5 suppressed, edge 6 accepted; next PPS gives COUNT=2, SUPPRESSED=1.
- Handshake/overrun:
  - Two PPS rises with no ACK -> OVERRUN=1, COUNT holds the second interval's value.
  - ACK -> VALID=0, OVERRUN=0.
  - ACK coincident with PPS_RISE -> VALID=1, OVERRUN=0.
- Same-cycle boundary: TRIG accepted in the PPS_RISE cycle -> latched COUNT excludes it; next interval's COUNT includes it (=1 if no other triggers).
- Saturation/disable:
  - CNT_WIDTH=4, 20 triggers -> COUNT=15.
  - ENABLE=0 with 5 triggers -> COUNT=0, SUPPRESSED=0, no TRIG_OUT.
- Reset mid-holdoff: HOLDOFF=100, accept, RESET at +10 cycles, TRIG 2 cycles after RESET deasserts -> accepted, all outputs 0 during reset.
